// File: rtl/bcd_subtractor_serial.sv
`default_nettype none
// ============================================================================
// Module      : bcd_subtractor_serial
// Description : Digit-serial packed-BCD subtractor, diff = a - b - bin, LSD
//               first, ten's-complement result with borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  b_out,
    output logic                  err
);

    localparam int              c_W    = 4 * DIGITS;
    localparam int              c_CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIGITS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [c_W-1:0]  r_a;
    logic [c_W-1:0]  r_b;
    logic [c_W-1:0]  r_diff;
    logic [c_CW-1:0] r_cnt;
    logic            r_brw;
    logic            r_bout;
    logic            r_err;
    logic            r_done;
    logic            r_busy;
    logic            r_rej;

    logic            w_bad;
    logic [3:0]      w_ak;
    logic [3:0]      w_bk;
    logic [4:0]      w_t;
    logic [3:0]      w_digit;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                w_bad = 1'b1;
            end
        end
    end

    // 5-bit two's-complement difference; bit 4 set means the digit borrowed
    assign w_ak    = r_a[4*r_cnt +: 4];
    assign w_bk    = r_b[4*r_cnt +: 4];
    assign w_t     = {1'b0, w_ak} - {1'b0, w_bk} - {4'b0000, r_brw};
    assign w_digit = w_t[4] ? (w_t[3:0] + 4'd10) : w_t[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_brw   <= 1'b0;
            r_bout  <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_rej   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // Rejected operands take one extra IDLE cycle so err and
                    // done appear together one edge after the capture edge.
                    if (r_rej) begin
                        r_rej   <= 1'b0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end else if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_brw  <= bin;
                        r_cnt  <= '0;
                        r_diff <= '0;
                        r_bout <= 1'b0;
                        r_err  <= 1'b0;
                        if (w_bad) begin
                            r_rej <= 1'b1;
                        end else begin
                            r_state <= c_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                c_CALC: begin
                    r_diff[4*r_cnt +: 4] <= w_digit;
                    r_brw                <= w_t[4];
                    r_cnt                <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_bout  <= w_t[4];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign diff  = r_diff;
    assign b_out = r_bout;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_subtractor_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_subtractor_serial
// Description : Scoreboard bench for the digit-serial BCD subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_subtractor_serial;

    localparam int DIGITS = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        bin   = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        b_out;
    logic        err;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                me = q.pop_front();
                check("diff", {16'h0, diff}, {16'h0, me.diff});
                check("b_out", {31'h0, b_out}, {31'h0, me.bout});
                check("err", {31'h0, err}, {31'h0, me.err});
                check("done_cycle", cyc, me.cyc);
                check("busy_at_done", {31'h0, busy}, 32'h0);
            end
        end
    end

    task automatic push_exp(input logic [15:0] ed, input logic eb, input logic ee, input int at);
        exp_t e;
        e.diff = ed;
        e.bout = eb;
        e.err  = ee;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic drain(output bit busy_seen);
        busy_seen = 1'b0;
        for (int i = 0; i < 30 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d results pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                         input logic [15:0] ed, input logic eb, input logic ee);
        bit bs;
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(ed, eb, ee, cyc + (ee ? 1 : DIGITS));
        check("busy_after_start", {31'h0, busy}, {31'h0, ~ee});
        check("err_cleared_at_start", {31'h0, err}, 32'h0);
        check("diff_cleared_at_start", {16'h0, diff}, 32'h0);
        drain(bs);
        if (ee) check("busy_never_rises", {31'h0, bs}, 32'h0);
    endtask

    initial begin : stim
        bit bs;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_diff", {16'h0, diff}, 32'h0);
        check("reset_bout", {31'h0, b_out}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        rst = 1'b0;

        do_op(16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0);
        do_op(16'h0905, 16'h0905, 1'b1, 16'h9999, 1'b1, 1'b0);
        do_op(16'h5000, 16'h0001, 1'b1, 16'h4998, 1'b0, 1'b0);
        do_op(16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0, 1'b0);
        do_op(16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0, 1'b0);
        do_op(16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
        do_op(16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0);

        // start pulsed mid-calculation with other operands must be ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h0567; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(16'h0667, 1'b0, 1'b0, cyc + DIGITS);
        @(negedge clk);
        a = 16'h9999; b = 16'h1111; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(bs);
        repeat (8) @(negedge clk);

        // start held high: second operation accepted 6 edges after the first
        @(negedge clk);
        a = 16'h5000; b = 16'h0001; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(16'h4998, 1'b0, 1'b0, cyc + DIGITS);
        push_exp(16'h4998, 1'b0, 1'b0, cyc + DIGITS + 6);
        repeat (8) @(negedge clk);
        start = 1'b0;
        drain(bs);
        repeat (8) @(negedge clk);

        // asynchronous reset in the middle of a calculation
        @(negedge clk);
        a = 16'h1234; b = 16'h0567; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_diff", {16'h0, diff}, 32'h0);
        check("abort_bout", {31'h0, b_out}, 32'h0);
        check("abort_err", {31'h0, err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        do_op(16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
